// File: rtl/router_fifo_if.sv
// router_fifo_if
//  Handshake and data bundle between router_sync/output channel and one router_fifo.
//  slave  : the FIFO side (takes write/read requests, drives data_out and status)
//  master : the driving side (router_sync + output channel, or a testbench)
//  Signals: write_enb, lfd_state, data_in, read_enb  (master -> slave)
//           data_out, full, empty, pkt_active        (slave -> master)
interface router_fifo_if #(
    parameter int WIDTH = 8
);
    logic             write_enb;
    logic             lfd_state;
    logic [WIDTH-1:0] data_in;
    logic             read_enb;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             pkt_active;

    modport slave (
        input  write_enb, lfd_state, data_in, read_enb,
        output data_out, full, empty, pkt_active
    );

    modport master (
        output write_enb, lfd_state, data_in, read_enb,
        input  data_out, full, empty, pkt_active
    );
endinterface

// File: rtl/router_fifo.sv
// router_fifo
//  Per-destination output buffer of the 1:3 router. Stores {header tag, byte} words,
//  decodes the payload length of each header as it is read out and counts the packet
//  down so the consumer can tell when the last byte (parity) has left.
//  Ports:
//    clock       rising-edge clock
//    reset       synchronous active-high reset
//    soft_reset  synchronous flush (read timeout from router_sync), same effect as reset
//    bus         router_fifo_if slave: write_enb/lfd_state/data_in/read_enb in,
//                data_out (registered), full, empty, pkt_active out
module router_fifo #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          soft_reset,
    router_fifo_if.slave  bus
);
    logic [WIDTH:0]   mem [DEPTH];
    logic [ADDR_W:0]  wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W:0]  rd_ptr_reg, rd_ptr_next;
    logic [6:0]       pkt_cnt_reg, pkt_cnt_next;
    logic [WIDTH-1:0] data_out_reg, data_out_next;
    logic [WIDTH:0]   rd_word;
    logic             full, empty, flush, wr_ok, rd_ok;

    // Pointer MSB is the wrap bit: equal low bits with differing wrap bits means full.
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);

    assign flush = reset || soft_reset;
    // Legality uses pre-edge status, so a read at full never frees room for a
    // same-cycle write, and a write to an empty FIFO is not readable until later.
    assign wr_ok = bus.write_enb && !full;
    assign rd_ok = bus.read_enb && !empty;

    assign rd_word = mem[rd_ptr_reg[ADDR_W-1:0]];

    // Storage has no reset; a flush simply makes the old words unreachable.
    always_ff @(posedge clock) begin
        if (wr_ok && !flush) begin
            mem[wr_ptr_reg[ADDR_W-1:0]] <= {bus.lfd_state, bus.data_in};
        end
    end

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        pkt_cnt_next  = pkt_cnt_reg;
        data_out_next = data_out_reg;
        if (wr_ok) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (rd_ok) begin
            rd_ptr_next   = rd_ptr_reg + 1'b1;
            data_out_next = rd_word[WIDTH-1:0];
            if (rd_word[WIDTH]) begin
                // Header: length field plus the trailing parity byte.
                pkt_cnt_next = 7'(rd_word[WIDTH-1:2]) + 7'd1;
            end else if (pkt_cnt_reg != 7'd0) begin
                pkt_cnt_next = pkt_cnt_reg - 7'd1;
            end
        end else if (pkt_cnt_reg == 7'd0) begin
            // Between packets the output bus idles at zero.
            data_out_next = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            pkt_cnt_reg  <= '0;
            data_out_reg <= '0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            pkt_cnt_reg  <= pkt_cnt_next;
            data_out_reg <= data_out_next;
        end
    end

    assign bus.data_out   = data_out_reg;
    assign bus.full       = full;
    assign bus.empty      = empty;
    assign bus.pkt_active = (pkt_cnt_reg != 7'd0);
endmodule
